// File: rtl/apb_capture_pkg.sv
// Shared types for the APB transaction capture block: bus-phase encoding,
// the captured-transfer record and a saturating wait counter helper.
package apb_capture_pkg;

  localparam int TXN_ADDR_W = 32;
  localparam int TXN_DATA_W = 32;
  localparam logic [7:0] WAIT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } apb_phase_e;

  typedef struct packed {
    logic [TXN_ADDR_W-1:0] addr;
    logic [TXN_DATA_W-1:0] data;
    logic                  write;
    logic                  slverr;
    logic [7:0]            wait_cnt;
  } apb_txn_t;

  // Wait-state counter increment that sticks at its maximum value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == WAIT_MAX) begin
      return WAIT_MAX;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/apb_capture_fifo.sv
// Capture FIFO: registered valid, head entry read straight from storage so it
// stays put until popped. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is dropped and o_drop pulses.
module apb_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;

  logic             w_full;
  logic             w_pop;
  logic             w_do_push;
  logic [CW-1:0]    w_count_nxt;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = r_valid & i_pop_ready;
  assign w_do_push = i_push & (~w_full | w_pop);
  assign o_drop    = i_push & w_full & ~w_pop;
  assign o_valid   = r_valid;
  assign o_data    = r_mem[r_rd_ptr];

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1'b1);
    end else if (w_pop && !w_do_push) begin
      w_count_nxt = r_count - CW'(1'b1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Storage, wrapping pointers, occupancy and registered valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1'b1);
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

endmodule

// File: rtl/apb_txn_capture.sv
// Passive APB monitor: follows the bus phase, records each completed transfer
// (address/direction from the setup cycle, data and slverr from the completion
// cycle, number of wait states) into a FIFO, and raises sticky flags for
// protocol violations and for transfers dropped because the FIFO was full.
// The FSM state names the phase seen in the previous cycle, so SETUP/ACCESS
// mean "this cycle must be an access cycle of the transfer in flight".
module apb_txn_capture
  import apb_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  txn_valid,
  input  logic                  txn_ready,
  output apb_txn_t              txn_data,
  output logic                  proto_err,
  output logic                  overflow
);

  localparam int TXN_W = $bits(apb_txn_t);

  apb_phase_e            r_state;
  apb_phase_e            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  r_write;
  logic                  w_write_nxt;
  logic [7:0]            r_wait;
  logic [7:0]            w_wait_nxt;
  logic                  w_push;
  logic                  w_err;
  apb_txn_t              w_push_txn;
  logic                  r_proto_err;
  logic                  r_overflow;
  logic                  w_drop;
  logic [TXN_W-1:0]      w_head;

  // Phase tracking, violation detection and completion decode.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_write_nxt = r_write;
    w_wait_nxt  = r_wait;
    w_push      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      PH_IDLE: begin
        if (penable) begin
          w_err       = 1'b1;
          w_state_nxt = PH_IDLE;
        end else if (psel) begin
          w_state_nxt = PH_SETUP;
          w_addr_nxt  = paddr;
          w_write_nxt = pwrite;
          w_wait_nxt  = 8'd0;
        end else begin
          w_state_nxt = PH_IDLE;
        end
      end
      PH_SETUP, PH_ACCESS: begin
        if (!(psel && penable)) begin
          // missing access after setup, or psel/penable dropped before pready
          w_err       = 1'b1;
          w_state_nxt = PH_IDLE;
        end else if ((paddr != r_addr) || (pwrite != r_write)) begin
          w_err       = 1'b1;
          w_state_nxt = PH_IDLE;
        end else if (pready) begin
          w_push      = 1'b1;
          w_state_nxt = PH_IDLE;
        end else begin
          w_state_nxt = PH_ACCESS;
          w_wait_nxt  = sat_inc8(r_wait);
        end
      end
      default: begin
        w_state_nxt = PH_IDLE;
      end
    endcase
  end

  // Record assembled on the completion cycle.
  always_comb begin
    w_push_txn          = '0;
    w_push_txn.addr     = TXN_ADDR_W'(r_addr);
    w_push_txn.data     = r_write ? TXN_DATA_W'(pwdata) : TXN_DATA_W'(prdata);
    w_push_txn.write    = r_write;
    w_push_txn.slverr   = pslverr;
    w_push_txn.wait_cnt = r_wait;
  end

  // Phase state plus the setup-cycle latches and wait counter.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= PH_IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wait  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_write <= w_write_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_proto_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_err) begin
        r_proto_err <= 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  apb_capture_fifo #(
    .WIDTH (TXN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (pclk),
    .rst_n       (preset_n),
    .i_push      (w_push),
    .i_push_data (w_push_txn),
    .i_pop_ready (txn_ready),
    .o_valid     (txn_valid),
    .o_data      (w_head),
    .o_drop      (w_drop)
  );

  assign txn_data  = apb_txn_t'(w_head);
  assign proto_err = r_proto_err;
  assign overflow  = r_overflow;

endmodule

// File: doc/apb_txn_capture.md
APB_TXN_CAPTURE -- requirements
Module: apb_txn_capture

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, paddr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, pwdata/prdata width.
REQ-003 SHALL have parameter DEPTH, default 4, capture FIFO entries (power of two, >=2).
REQ-004 SHALL have port pclk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port preset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports psel, penable, pwrite, pready, pslverr  input  1 each  sampled APB bus pins.
REQ-007 SHALL have port paddr  input  ADDR_WIDTH  sampled address.
REQ-008 SHALL have ports pwdata, prdata  input  DATA_WIDTH  sampled write/read data.
REQ-009 SHALL have port txn_valid  output  1  captured transfer available to monitor.
REQ-010 SHALL have port txn_ready  input  1  monitor consumes head entry.
REQ-011 SHALL have port txn_data  output  apb_txn_t  head entry: addr, data, write, slverr, wait_cnt[7:0].
REQ-012 SHALL have port proto_err  output  1  sticky protocol-violation flag.
REQ-013 SHALL have port overflow  output  1  sticky dropped-transfer flag.

Function
REQ-014 SHALL track bus phase with FSM IDLE, SETUP, ACCESS.
REQ-015 SHALL go IDLE->SETUP on psel&!penable; SETUP->ACCESS on psel&penable the next cycle.
REQ-016 SHALL stay in ACCESS while psel&penable&!pready, incrementing wait_cnt per cycle, saturating at 255.
REQ-017 SHALL, on psel&penable&pready in ACCESS, complete the transfer: data = pwrite ? pwdata : prdata, addr/pwrite latched in SETUP, slverr = pslverr.
REQ-018 SHALL go ACCESS->SETUP on completion if psel&!penable is also seen next cycle (back-to-back), else ->IDLE.
REQ-019 SHALL set proto_err on: penable in IDLE; SETUP not followed by penable; paddr or pwrite changing during ACCESS; psel dropping in ACCESS before pready. FSM then returns to IDLE.
REQ-020 SHALL push the completed transfer into the FIFO on the completion cycle; txn_valid rises the following cycle (latency 1).
REQ-021 SHALL hold txn_data stable while txn_valid&!txn_ready; pop on txn_valid&txn_ready.
REQ-022 SHALL, on push and pop in the same cycle with FIFO full, accept both (occupancy unchanged).
REQ-023 SHALL, on push with FIFO full and no pop, drop the new transfer and set overflow.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-025 SHALL not drive any APB pin (passive observer).

Reset
REQ-026 SHALL, on preset_n low, immediately set FSM IDLE, FIFO empty, txn_valid=0, txn_data=0, proto_err=0, overflow=0, wait_cnt=0.
REQ-027 SHALL discard any in-flight transfer when reset asserts mid-ACCESS; no entry is produced for it.
REQ-028 SHALL resume capture on the first rising pclk after preset_n deasserts.

Structure
REQ-029 SHALL take apb_txn_t and phase enum from shared package apb_capture_pkg.
REQ-030 SHALL implement buffering in sub-module apb_capture_fifo (parameterised width/DEPTH).

Verification
REQ-031 Write 0x10 <= 0xCAFE, zero waits, txn_ready=1 -> one entry {0x10,0xCAFE,write=1,slverr=0,wait_cnt=0}, txn_valid high 1 cycle after completion.
REQ-032 Read 0x20, pready low 3 cycles, prdata 0x55 -> entry {0x20,0x55,write=0,wait_cnt=3}.
REQ-033 Five back-to-back writes, txn_ready=0, DEPTH=4 -> 4 entries in order, 5th dropped, overflow=1.
REQ-034 penable high with FSM IDLE -> proto_err=1, no entry pushed.
REQ-035 preset_n low during ACCESS of read 0x30 -> after release FIFO empty, txn_valid=0, flags clear.
REQ-036 FIFO full, completion and txn_ready=1 same cycle -> occupancy stays 4, overflow stays 0, order preserved.
